// File: rtl/stash_pkg.sv
// Shared constants and FSM state type for the stash sequencer.
// The auto-scan feature is built only when STASH_CTRL_AUTO_SCAN_EN is defined.
package stash_pkg;

  localparam int DEPTH_DEF       = 5;
  localparam int GUARD_DEF       = 2;
  localparam int SCAN_PERIOD_DEF = 100000000;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_CAP     = 2'd1;
  localparam state_t S_GUARD_W = 2'd2;
  localparam state_t S_BRW     = 2'd3;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stash_ctrl_scan_timer.sv
// Free-running browse timer: one-cycle tick every PERIOD enabled cycles.
// Used by stash_ctrl only when STASH_CTRL_AUTO_SCAN_EN is defined.
module scan_timer
  import stash_pkg::*;
#(
  parameter int PERIOD = SCAN_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = cw(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stash_ctrl.sv
// Capture/browse sequencer driving write and browse strobes toward a stash.
// Define STASH_CTRL_AUTO_SCAN_EN to add scan_en and the periodic auto-browse.
module stash_ctrl
  import stash_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int GUARD       = GUARD_DEF,
  parameter int SCAN_PERIOD = SCAN_PERIOD_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lap_req,
  input  logic                         browse_req,
  input  logic [7:0]                   time_in,
  input  logic                         freeze,
`ifdef STASH_CTRL_AUTO_SCAN_EN
  input  logic                         scan_en,
`endif
  output logic [7:0]                   sample_in,
  output logic                         sample_in_valid,
  output logic                         next_sample,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = cw(GUARD);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [GW-1:0] GLAST   = GW'(GUARD - 1);

  state_t        state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    smp_q, smp_d;
  logic          pend_q, pend_d;
  logic          vld_q, vld_d;
  logic          nxt_q, nxt_d;
  logic          cap_go, scan_tick, brw_in, pend_now, guard_done;

  assign cap_go = (state_q == S_IDLE) & lap_req & ~freeze;

`ifdef STASH_CTRL_AUTO_SCAN_EN
  scan_timer #(.PERIOD(SCAN_PERIOD)) u_scan (
    .clk  (clk),
    .reset(reset),
    .en   (scan_en),
    .clr  (cap_go),
    .tick (scan_tick)
  );
`else
  assign scan_tick = 1'b0;
`endif

  assign brw_in   = browse_req | scan_tick;
  assign pend_now = pend_q | brw_in;
  assign guard_done =
    ((state_q == S_CAP) && (GUARD == 0)) ||
    ((state_q == S_GUARD_W) && (gcnt_q == '0));

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    count_d = count_q;
    smp_d   = smp_q;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    nxt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cap_go) begin
          state_d = S_CAP;
          vld_d   = 1'b1;
          smp_d   = time_in;
          pend_d  = pend_now;
          if (count_q != DEPTH_C) count_d = count_q + 1'b1;
        end else if (pend_q || (brw_in && count_q >= CW'(2))) begin
          state_d = S_BRW;
          nxt_d   = 1'b1;
          pend_d  = 1'b0;
        end
      end
      S_CAP: begin
        state_d = S_GUARD_W;
        gcnt_d  = GLAST;
        pend_d  = pend_now;
      end
      S_GUARD_W: begin
        gcnt_d = gcnt_q - 1'b1;
        pend_d = pend_now;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = brw_in;
      end
    endcase
    // Guard exit hands a pending browse straight to BRW.
    if (guard_done) begin
      if (pend_now) begin
        state_d = S_BRW;
        nxt_d   = 1'b1;
        pend_d  = 1'b0;
      end else begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gcnt_q  <= '0;
      count_q <= '0;
      smp_q   <= '0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      nxt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      count_q <= count_d;
      smp_q   <= smp_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      nxt_q   <= nxt_d;
    end
  end

  assign sample_in       = smp_q;
  assign sample_in_valid = vld_q;
  assign next_sample     = nxt_q;
  assign count           = count_q;
  assign full            = (count_q == DEPTH_C);

endmodule

// File: tb/tb_stash_ctrl.sv
// Directed self-checking bench for stash_ctrl.
module tb_stash_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lap_req = 1'b0;
  logic       browse_req = 1'b0;
  logic [7:0] time_in = 8'h00;
  logic       freeze = 1'b0;
`ifdef STASH_CTRL_AUTO_SCAN_EN
  logic       scan_en = 1'b0;
`endif
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;
  logic [2:0] count;
  logic       full;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stash_ctrl #(
    .DEPTH      (5),
    .GUARD      (2),
    .SCAN_PERIOD(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lap_req        (lap_req),
    .browse_req     (browse_req),
    .time_in        (time_in),
    .freeze         (freeze),
`ifdef STASH_CTRL_AUTO_SCAN_EN
    .scan_en        (scan_en),
`endif
    .sample_in      (sample_in),
    .sample_in_valid(sample_in_valid),
    .next_sample    (next_sample),
    .count          (count),
    .full           (full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input logic [7:0] v, input int exp_cnt);
    time_in = v;
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    chk("cap_vld", 32'(sample_in_valid), 1);
    chk("cap_smp", 32'(sample_in), 32'(v));
    chk("cap_cnt", 32'(count), 32'(exp_cnt));
    chk("cap_full", 32'(full), (exp_cnt == 5) ? 1 : 0);
    chk("cap_nxt", 32'(next_sample), 0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_vld", 32'(sample_in_valid), 0);
    chk("rst_nxt", 32'(next_sample), 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_smp", 32'(sample_in), 0);
    reset = 1'b1;
    repeat (7) tick();

    // first capture
    time_in = 8'h12;
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    time_in = 8'hAA;
    chk("lap1_vld", 32'(sample_in_valid), 1);
    chk("lap1_smp", 32'(sample_in), 32'h12);
    chk("lap1_cnt", 32'(count), 1);
    tick();
    chk("g1_vld", 32'(sample_in_valid), 0);
    chk("g1_hold", 32'(sample_in), 32'h12);
    tick();
    tick();

    // browse with count=1 dropped
    browse_req = 1'b1;
    tick();
    browse_req = 1'b0;
    chk("brw_c1_a", 32'(next_sample), 0);
    tick();
    chk("brw_c1_b", 32'(next_sample), 0);

    // freeze blocks capture
    freeze  = 1'b1;
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    freeze  = 1'b0;
    chk("frz_vld", 32'(sample_in_valid), 0);
    chk("frz_cnt", 32'(count), 1);

    cap(8'h21, 2);
    cap(8'h22, 3);

    // simultaneous lap and browse
    time_in    = 8'h55;
    lap_req    = 1'b1;
    browse_req = 1'b1;
    tick();
    lap_req    = 1'b0;
    browse_req = 1'b0;
    chk("sim_n1_vld", 32'(sample_in_valid), 1);
    chk("sim_n1_nxt", 32'(next_sample), 0);
    chk("sim_n1_cnt", 32'(count), 4);
    tick();
    chk("sim_n2_nxt", 32'(next_sample), 0);
    tick();
    chk("sim_n3_nxt", 32'(next_sample), 0);
    tick();
    chk("sim_n4_nxt", 32'(next_sample), 1);
    chk("sim_n4_vld", 32'(sample_in_valid), 0);
    tick();
    chk("sim_n5_nxt", 32'(next_sample), 0);

    cap(8'h66, 5);
    cap(8'h77, 5);

    // plain browse from IDLE
    browse_req = 1'b1;
    tick();
    browse_req = 1'b0;
    chk("brw_nxt", 32'(next_sample), 1);
    chk("brw_vld", 32'(sample_in_valid), 0);
    tick();
    chk("brw_end", 32'(next_sample), 0);

    // lap outside IDLE dropped
    time_in = 8'h88;
    lap_req = 1'b1;
    tick();
    chk("drop_cap", 32'(sample_in), 32'h88);
    time_in = 8'h99;
    tick();
    lap_req = 1'b0;
    chk("drop_g1", 32'(sample_in_valid), 0);
    tick();
    chk("drop_g2", 32'(sample_in_valid), 0);
    tick();
    chk("drop_idle", 32'(sample_in_valid), 0);
    chk("drop_smp", 32'(sample_in), 32'h88);
    chk("drop_cnt", 32'(count), 5);

    // reset during CAP
    time_in = 8'h44;
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    reset   = 1'b0;
    tick();
    chk("mrst_vld", 32'(sample_in_valid), 0);
    chk("mrst_nxt", 32'(next_sample), 0);
    chk("mrst_cnt", 32'(count), 0);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_smp", 32'(sample_in), 0);
    reset = 1'b1;
    tick();
    chk("post_vld", 32'(sample_in_valid), 0);
    chk("post_nxt", 32'(next_sample), 0);

`ifdef STASH_CTRL_AUTO_SCAN_EN
    cap(8'h31, 1);
    cap(8'h32, 2);
    scan_en = 1'b1;
    time_in = 8'h33;
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    chk("scan_cap", 32'(sample_in_valid), 1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("scan_%0d", i), 32'(next_sample),
          (i % 4 == 0) ? 1 : 0);
    end
    scan_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stash_ctrl.md
STASH_CTRL -- requirements
Module: stash_ctrl

Interface
REQ-001 Parameter DEPTH, default 5, number of stash entries being sequenced.
REQ-002 Parameter GUARD, default 2, idle cycles enforced after each capture.
REQ-003 Parameter SCAN_PERIOD, default 100000000, clock cycles between auto-browse steps.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 lap_req  input  1  single-cycle request to capture the current time.
REQ-007 browse_req  input  1  single-cycle request to show the next stored sample.
REQ-008 time_in  input  8  live time value to be captured.
REQ-009 freeze  input  1  when high, lap_req is ignored.
REQ-010 sample_in  output  8  registered captured value toward the stash.
REQ-011 sample_in_valid  output  1  registered one-cycle write strobe toward the stash.
REQ-012 next_sample  output  1  registered one-cycle browse strobe toward the stash.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid stored entries, saturating at DEPTH.
REQ-014 full  output  1  high when count equals DEPTH.

Function
REQ-015 FSM states: IDLE, CAP, GUARD_W, BRW; encoding is free.
REQ-016 IDLE + lap_req & !freeze -> CAP; time_in is latched in the same edge.
REQ-017 CAP lasts one cycle and drives sample_in_valid=1, with sample_in equal to the value latched at the request; latency is request at cycle N -> strobe at cycle N+1.
REQ-018 CAP -> GUARD_W, which lasts exactly GUARD cycles with no strobes; then -> BRW if a browse is pending, else IDLE.
REQ-019 Each CAP increments count, saturating at DEPTH; full holds while count==DEPTH, and further captures still write (stash overwrites oldest).
REQ-020 IDLE + browse_req & count>=2 & no lap_req -> BRW; BRW lasts one cycle with next_sample=1, then -> IDLE.
REQ-021 browse_req with count<2 is dropped silently.
REQ-022 Simultaneous lap_req and browse_req in IDLE: capture wins, and the browse is set pending.
REQ-023 browse_req arriving in CAP, GUARD_W or BRW sets a one-bit pending flag; further requests while pending are dropped.
REQ-024 A pending browse is served from BRW on GUARD_W exit, or from IDLE on the next cycle; the flag clears when next_sample is driven.
REQ-025 lap_req arriving outside IDLE is dropped.
REQ-026 sample_in_valid and next_sample are never high in the same cycle.
REQ-027 sample_in holds its last captured value when sample_in_valid is low.

Reset
REQ-028 While reset=0 at a clock edge: state=IDLE, count=0, full=0, pending=0, sample_in=0, sample_in_valid=0, next_sample=0, scan counter=0.
REQ-029 Reset asserted mid-CAP or mid-GUARD_W aborts the operation; no strobe is issued in the cycle after reset is released.

Configuration
REQ-030 Macro STASH_CTRL_AUTO_SCAN_EN, when defined, adds input scan_en (1 bit).
REQ-031 With the macro, while scan_en=1 a free-running counter generates an internal browse request every SCAN_PERIOD cycles, arbitrated exactly like browse_req (OR-ed into it).
REQ-032 With the macro, the counter clears when scan_en=0 or on any capture.
REQ-033 Without the macro, no scan_en port and no scan counter exist.

Structure
REQ-034 The FSM state type and the default parameter constants live in shared package stash_pkg.
REQ-035 The scan timer is a sub-module scan_timer (period parameter, enable, clear, one-cycle tick output).
REQ-036 The block does not instantiate the stash; top level connects the stash_ctrl outputs to its ports.

Verification
REQ-037 Reset, then lap_req with time_in=8'h12 at cycle 10 -> sample_in_valid=1 and sample_in=8'h12 at cycle 11, count=1.
REQ-038 lap_req and browse_req in the same cycle with count=3 -> capture strobe at N+1, next_sample exactly at N+1+GUARD+1 (N+4 with default GUARD).
REQ-039 Six captures with DEPTH=5 -> count=5 and full=1 after the fifth capture; the sixth still strobes while count stays 5.
REQ-040 browse_req with count=1 -> no next_sample; freeze=1 with lap_req -> no sample_in_valid.
REQ-041 reset=0 one cycle after lap_req, during CAP -> all outputs 0 and count=0 on the next cycle.
REQ-042 With STASH_CTRL_AUTO_SCAN_EN, SCAN_PERIOD=4, count=2, scan_en=1 -> next_sample every 4 cycles; a capture restarts the 4-cycle spacing.
